noc_rr_timeout_arbiter: RTL and testbench

Parametrised output-port arbiter for the NoC router. It grants one of `NPORTS` input ports at a time, with round-robin rotation. Each grant lasts until the requester drops its request or its per-port packet timer expires. It generalises the fixed five-port arbiter to any port count and length width, adds a rotating priority pointer that survives idle periods, and adds a timeout-event output. It sits between the input-port request logic and the crossbar select.

---
 rtl/noc_arb_pkg.sv | 23 ++
 rtl/arb_port_timer.sv | 31 +++
 rtl/noc_rr_timeout_arbiter.sv | 104 ++++++++++
 tb/tb_noc_rr_timeout_arbiter.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/noc_arb_pkg.sv
// Shared constants for the NoC output-port arbiter: header flit code, port indices
// and the pointer-width helper.
package noc_arb_pkg;

    localparam logic [2:0] HEADER_ID = 3'b001;

    typedef enum logic [2:0] {
        PORT_L = 3'd0,
        PORT_N = 3'd1,
        PORT_E = 3'd2,
        PORT_W = 3'd3,
        PORT_S = 3'd4
    } port_e;

    localparam int NPORTS_DEF = 5;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int PTR_W_DEF = ptr_width(NPORTS_DEF);

endpackage

// File: rtl/arb_port_timer.sv
// Per-port packet timer: latched limit from header flits and a hold counter that
// flags expiry once the counter reaches the limit.
module arb_port_timer #(
    parameter int LEN_W = 12
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [LEN_W-1:0] i_length,
    input  logic             i_hold,
    output logic             o_expired
);

    logic [LEN_W-1:0] r_lim;
    logic [LEN_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_lim <= '0;
            r_cnt <= '0;
        end else begin
            if (i_load)
                r_lim <= i_length;
            // Counter only advances while holding, so the >= compare stops it before wrap.
            r_cnt <= i_hold ? r_cnt + 1'b1 : '0;
        end
    end

    assign o_expired = (r_cnt >= r_lim);

endmodule

// File: rtl/noc_rr_timeout_arbiter.sv
// Round-robin output-port arbiter with per-port packet timeouts. The grant vector is
// the FSM state: zero = idle, one-hot = granted port, anything else recovers to idle.
module noc_rr_timeout_arbiter #(
    parameter int               NPORTS    = 5,
    parameter int               LEN_W     = 12,
    parameter int               FID_W     = 3,
    parameter logic [FID_W-1:0] HEADER_ID = FID_W'(noc_arb_pkg::HEADER_ID)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [NPORTS*FID_W-1:0] i_flit_id,
    input  logic [NPORTS*LEN_W-1:0] i_length,
    input  logic [NPORTS-1:0]       i_req,
    output logic [NPORTS-1:0]       o_grant,
    output logic                    o_busy,
    output logic [NPORTS-1:0]       o_timeout
);

    import noc_arb_pkg::*;

    localparam int PTR_W = ptr_width(NPORTS);

    logic [NPORTS-1:0] r_grant;
    logic [NPORTS-1:0] r_timeout;
    logic [PTR_W-1:0]  r_ptr;

    logic [NPORTS-1:0] w_grant_nxt;
    logic [NPORTS-1:0] w_timeout_nxt;
    logic [PTR_W-1:0]  w_ptr_nxt;
    logic [NPORTS-1:0] w_hold;
    logic [NPORTS-1:0] w_expired;
    logic [NPORTS-1:0] w_load;
    logic [NPORTS-1:0] w_win_oh;
    logic [PTR_W-1:0]  w_win;
    logic              w_found;
    logic              w_legal;
    int                w_idx;

    assign w_legal = ((r_grant & (r_grant - 1'b1)) == '0);

    for (genvar g = 0; g < NPORTS; g++) begin : g_port
        assign w_load[g] = (i_flit_id[g*FID_W +: FID_W] == HEADER_ID);
        assign w_hold[g] = w_legal & r_grant[g] & i_req[g] & ~w_expired[g];

        arb_port_timer #(.LEN_W(LEN_W)) u_timer (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .i_load    (w_load[g]),
            .i_length  (i_length[g*LEN_W +: LEN_W]),
            .i_hold    (w_hold[g]),
            .o_expired (w_expired[g])
        );
    end

    // Scan starts after the last grantee, so the current holder is considered last.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = 0;
        for (int k = 1; k <= NPORTS; k++) begin
            w_idx = (int'(r_ptr) + k) % NPORTS;
            if (!w_found && i_req[w_idx]) begin
                w_found = 1'b1;
                w_win   = PTR_W'(w_idx);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_grant   <= '0;
            r_ptr     <= PTR_W'(NPORTS - 1);
            r_timeout <= '0;
        end else begin
            r_grant   <= w_grant_nxt;
            r_ptr     <= w_ptr_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_win_oh = '0;
        if (w_found)
            w_win_oh[w_win] = 1'b1;
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_ptr;
        if (!w_legal) begin
            w_grant_nxt = '0;
        end else if (!(|w_hold)) begin
            w_grant_nxt = w_win_oh;
            if (w_found)
                w_ptr_nxt = w_win;
        end
        // A granted, still-requesting port that is not holding has just expired.
        w_timeout_nxt = r_grant & i_req & w_expired & {NPORTS{w_legal}};
    end

    always_comb begin
        o_grant   = r_grant;
        o_busy    = |r_grant;
        o_timeout = r_timeout;
    end

endmodule

// File: tb/tb_noc_rr_timeout_arbiter.sv
// Vector/scoreboard bench for the round-robin timeout arbiter (5 ports).
module tb_noc_rr_timeout_arbiter;

    localparam int NP = 5;
    localparam int LW = 12;
    localparam int FW = 3;
    localparam logic [FW-1:0] HDR    = 3'b001;
    localparam logic [FW-1:0] NONHDR = 3'b010;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP*FW-1:0]  flit_id;
    logic [NP*LW-1:0]  length;
    logic [NP-1:0]     req;
    logic [NP-1:0]     grant;
    logic              busy;
    logic [NP-1:0]     timeout;

    always #5 clk = ~clk;

    noc_rr_timeout_arbiter #(.NPORTS(NP), .LEN_W(LW), .FID_W(FW), .HEADER_ID(HDR)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_flit_id (flit_id),
        .i_length  (length),
        .i_req     (req),
        .o_grant   (grant),
        .o_busy    (busy),
        .o_timeout (timeout)
    );

    typedef struct {
        logic          r;
        logic [NP-1:0] rq;
        logic [NP-1:0] hd;
        logic [LW-1:0] ln;
        logic [NP-1:0] eg;
        logic [NP-1:0] et;
        int            tag;
    } vec_t;

    typedef struct {
        logic [NP-1:0] eg;
        logic [NP-1:0] et;
        int            tag;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    function automatic void add(input logic r, input logic [NP-1:0] rq, input logic [NP-1:0] hd,
                                input logic [LW-1:0] ln, input logic [NP-1:0] eg,
                                input logic [NP-1:0] et, input int tag);
        vec_t v;
        v.r = r; v.rq = rq; v.hd = hd; v.ln = ln; v.eg = eg; v.et = et; v.tag = tag;
        tbl.push_back(v);
    endfunction

    task automatic check();
        exp_t e;
        if (sb.size() == 0) begin
            n_miss++;
            $display("FAIL scoreboard empty at vector %0d", n_vec);
        end else begin
            e = sb.pop_front();
            n_vec++;
            if (grant !== e.eg) begin
                n_miss++;
                $display("FAIL grant tag=%0d vec=%0d got %b want %b", e.tag, n_vec, grant, e.eg);
            end
            if (busy !== (e.eg != '0)) begin
                n_miss++;
                $display("FAIL busy tag=%0d vec=%0d got %b want %b", e.tag, n_vec, busy, (e.eg != '0));
            end
            if (timeout !== e.et) begin
                n_miss++;
                $display("FAIL timeout tag=%0d vec=%0d got %b want %b", e.tag, n_vec, timeout, e.et);
            end
        end
    endtask

    // Drive one cycle of inputs (at the falling edge), expect outputs after the next rising edge.
    task automatic apply(input logic r, input logic [NP-1:0] rq, input logic [NP-1:0] hd,
                         input logic [LW-1:0] ln, input logic [NP-1:0] eg,
                         input logic [NP-1:0] et, input int tag);
        exp_t e;
        rst = r;
        req = rq;
        for (int p = 0; p < NP; p++) begin
            flit_id[p*FW +: FW] = hd[p] ? HDR : NONHDR;
            length[p*LW +: LW]  = ln;
        end
        e.eg = eg; e.et = et; e.tag = tag;
        sb.push_back(e);
        @(negedge clk);
        check();
    endtask

    initial begin
        rst = 1'b1; req = '0; flit_id = '0; length = '0;

        // Reset, then idle with no requests.
        add(1, 5'b00000, 5'b00000, 0, 5'b00000, 5'b00000, 1);
        add(1, 5'b00000, 5'b00000, 0, 5'b00000, 5'b00000, 1);
        for (int i = 0; i < 5; i++)
            add(0, 5'b00000, 5'b00000, 0, 5'b00000, 5'b00000, 2);
        // All ports lim=3, all requesting: 0,1,2,3,4,0 with 4 cycles each.
        add(0, 5'b00000, 5'b11111, 3, 5'b00000, 5'b00000, 3);
        for (int p = 0; p < 6; p++)
            for (int c = 0; c < 4; c++)
                add(0, 5'b11111, 5'b00000, 3, NP'(1 << (p % NP)),
                    (c == 0 && p > 0) ? NP'(1 << ((p - 1) % NP)) : NP'(0), 4);
        add(0, 5'b00000, 5'b00000, 3, 5'b00000, 5'b00000, 5);

        foreach (tbl[i])
            apply(tbl[i].r, tbl[i].rq, tbl[i].hd, tbl[i].ln, tbl[i].eg, tbl[i].et, tbl[i].tag);

        // Port 2 alone with lim=0: continuous re-grant, timeout every cycle after the first.
        apply(0, 5'b00000, 5'b00100, 0, 5'b00000, 5'b00000, 10);
        apply(0, 5'b00100, 5'b00000, 0, 5'b00100, 5'b00000, 11);
        for (int i = 0; i < 4; i++)
            apply(0, 5'b00100, 5'b00000, 0, 5'b00100, 5'b00100, 12);
        apply(0, 5'b00000, 5'b00000, 0, 5'b00000, 5'b00000, 13);

        // Port 3 lim=10 releases early without timeout; then 1 and 4 tie, 4 wins (ptr=3).
        apply(0, 5'b00000, 5'b01000, 10, 5'b00000, 5'b00000, 20);
        apply(0, 5'b01000, 5'b00000, 10, 5'b01000, 5'b00000, 21);
        apply(0, 5'b01000, 5'b00000, 10, 5'b01000, 5'b00000, 21);
        apply(0, 5'b00000, 5'b00000, 10, 5'b00000, 5'b00000, 22);
        apply(0, 5'b10010, 5'b00000, 10, 5'b10000, 5'b00000, 23);
        apply(0, 5'b00000, 5'b00000, 10, 5'b00000, 5'b00000, 24);

        // Port 0 lim=100, header with length 2 at cnt=5: released next cycle to port 1.
        apply(0, 5'b00000, 5'b00001, 100, 5'b00000, 5'b00000, 30);
        for (int i = 0; i < 6; i++)
            apply(0, 5'b00011, 5'b00000, 100, 5'b00001, 5'b00000, 31);
        apply(0, 5'b00011, 5'b00001, 2, 5'b00001, 5'b00000, 32);
        apply(0, 5'b00011, 5'b00000, 2, 5'b00010, 5'b00001, 33);
        apply(0, 5'b00000, 5'b00000, 2, 5'b00000, 5'b00000, 34);

        // Reset while port 1 holds at cnt=7; limits clear, pointer returns to port 0 start.
        apply(0, 5'b00000, 5'b00010, 20, 5'b00000, 5'b00000, 40);
        for (int i = 0; i < 8; i++)
            apply(0, 5'b00010, 5'b00000, 20, 5'b00010, 5'b00000, 41);
        apply(1, 5'b00010, 5'b00000, 20, 5'b00000, 5'b00000, 42);
        apply(0, 5'b01010, 5'b00000, 20, 5'b00010, 5'b00000, 43);
        apply(0, 5'b01010, 5'b00000, 20, 5'b01000, 5'b00010, 44);
        apply(0, 5'b00000, 5'b00000, 20, 5'b00000, 5'b00000, 45);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
